// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared types and defaults for the boot loader.
// Loader FSM states, parameter defaults, peripheral base address.
package imem_boot_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int MAX_WORDS_DEF  = 256;
  localparam int TIMEOUT_DEF    = 1000000;
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  typedef enum logic [2:0] {
    RUN,
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs UART bytes big-endian into 32-bit words.
// Ports: clk, reset (async high), clear (new load), byte_valid/byte_in
// in; word_valid (1-cycle pulse), word, xsum (XOR of bytes), last_byte
// (next accepted byte completes a word) out.
module imem_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  xsum,
  output logic        last_byte
);

  logic [1:0] cnt;

  assign last_byte = (cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      word       <= '0;
      xsum       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      word       <= '0;
      xsum       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && last_byte;
      if (byte_valid) begin
        word <= {word[23:0], byte_in};
        xsum <= xsum ^ byte_in;
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a UART-delivered program into instruction
// memory while holding the CPU in reset, then releases it.
// Ports: clk, reset, load_req, rx_valid/rx_data, cpu_pc in;
// imem_raddr (comb fetch index), imem_we/waddr/wdata (write port),
// cpu_hold, load_done, load_err, word_count out.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int MAX_WORDS      = MAX_WORDS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       cpu_pc,
  output logic [ADDR_W-1:0] imem_raddr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_n;

  logic [15:0]       nwords, nwords_n;
  logic [15:0]       nhdr;
  logic [IDLE_W-1:0] idle, idle_n;
  logic [ADDR_W-1:0] windex;
  logic              hold_n, done_n, err_n;
  logic              start, take;
  logic              active, timeout, last_word;
  logic              word_valid, last_byte;
  logic [31:0]       word;
  logic [7:0]        xsum;
  logic              unused_pc;

  assign imem_raddr = cpu_pc[ADDR_W+1:2];
  assign unused_pc  = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

  assign imem_we    = word_valid;
  assign imem_wdata = word;
  assign imem_waddr = windex;

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .byte_valid (take),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word),
    .xsum       (xsum),
    .last_byte  (last_byte)
  );

  assign active = (state == HDR_HI) || (state == HDR_LO) ||
                  (state == DATA)   || (state == CSUM);

  // A byte on the expiry cycle wins over the timeout.
  assign timeout = active && !rx_valid &&
                   (idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  assign idle_n = (!active || rx_valid) ? '0 : idle + 1'b1;

  assign nhdr = {nwords[15:8], rx_data};

  // Word being assembled now is the final one of the program.
  assign last_word = (17'(word_count) + 17'd1) == 17'(nwords);

  always_comb begin
    state_n  = state;
    hold_n   = cpu_hold;
    done_n   = load_done;
    err_n    = load_err;
    nwords_n = nwords;
    start    = 1'b0;
    take     = 1'b0;
    unique case (state)
      RUN, ERR: begin
        if (load_req) begin
          start   = 1'b1;
          state_n = HDR_HI;
          hold_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      HDR_HI: begin
        if (rx_valid) begin
          nwords_n[15:8] = rx_data;
          state_n        = HDR_LO;
        end
      end
      HDR_LO: begin
        if (rx_valid) begin
          nwords_n = nhdr;
          if (nhdr == 16'd0 || int'(nhdr) > MAX_WORDS) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          take = 1'b1;
          if (last_byte && last_word) state_n = CSUM;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == xsum) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ERR;
            err_n   = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = RUN;
        hold_n  = 1'b0;
      end
      default: begin
        state_n = RUN;
        hold_n  = 1'b0;
      end
    endcase
    if (timeout) begin
      state_n = ERR;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      nwords    <= '0;
      idle      <= '0;
    end else begin
      state     <= state_n;
      cpu_hold  <= hold_n;
      load_done <= done_n;
      load_err  <= err_n;
      nwords    <= nwords_n;
      idle      <= idle_n;
    end
  end

  // The final write lands in CSUM; the index stays on the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      windex     <= '0;
      word_count <= '0;
    end else if (start) begin
      windex     <= '0;
      word_count <= '0;
    end else if (word_valid) begin
      word_count <= word_count + 1'b1;
      if (state == DATA) windex <= windex + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized scoreboard bench for imem_boot_loader.
// Expected writes are queued at stimulus time; a negedge monitor checks.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] cpu_pc;
  logic [7:0]  imem_raddr;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [8:0]  word_count;

  imem_boot_loader #(
    .ADDR_W         (8),
    .MAX_WORDS      (256),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cpu_pc     (cpu_pc),
    .imem_raddr (imem_raddr),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int nwr  = 0;
  logic [39:0] expq[$];
  logic [31:0] prog[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      nwr++;
      chk("we_under_hold", 64'(cpu_hold), 64'd1);
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: got %0h/%0h want none",
                 imem_waddr, imem_wdata);
      end else begin
        chk("write", 64'({imem_waddr, imem_wdata}), 64'(expq.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    tick($urandom_range(0, 3));
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
  endtask

  task automatic make_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  function automatic logic [7:0] byte_of(input int i);
    logic [31:0] w;
    w = prog[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  function automatic logic [7:0] csum();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4 * prog.size(); i++) x ^= byte_of(i);
    return x;
  endfunction

  task automatic send_hdr(input int n);
    logic [15:0] nn;
    nn = 16'(n);
    send(nn[15:8]);
    gap();
    send(nn[7:0]);
  endtask

  // Bytes [from, to); a word's write is expected once its 4th byte goes.
  task automatic send_data(input int from, input int to);
    for (int i = from; i < to; i++) begin
      gap();
      if (i % 4 == 3) expq.push_back({8'(i / 4), prog[i / 4]});
      send(byte_of(i));
    end
  endtask

  // mode 0: plain, 1: load_req pulsed mid-data, 2: byte with load_req.
  task automatic full_load(input int n, input logic [7:0] c,
                           input bit ok, input int mode);
    int w0;
    w0 = nwr;
    if (mode == 2) begin
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      load_req = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      load_req = 1'b0;
    end else begin
      pulse_req();
    end
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_clear", 64'({load_done, load_err}), 64'd0);
    gap();
    send_hdr(n);
    if (mode == 1) begin
      send_data(0, 6);
      pulse_req();
      send_data(6, 4 * n);
    end else begin
      send_data(0, 4 * n);
    end
    gap();
    send(c);
    if (ok) begin
      chk("done_hold_1cyc", 64'(cpu_hold), 64'd1);
      chk("done_set", 64'(load_done), 64'd1);
      tick(1);
      chk("hold_fall", 64'(cpu_hold), 64'd0);
      chk("done_held", 64'(load_done), 64'd1);
    end else begin
      chk("err_set", 64'(load_err), 64'd1);
      tick(5);
      chk("err_hold", 64'({cpu_hold, load_err}), 64'd3);
    end
    chk("word_count", 64'(word_count), 64'(n));
    chk("writes", 64'(nwr - w0), 64'(n));
    chk("queue_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int w0;
    reset    = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cpu_pc   = 32'h0;
    tick(2);
    chk("rst_outputs",
        64'({cpu_hold, imem_we, imem_waddr, imem_wdata,
             load_done, load_err, word_count}), 64'd0);
    reset = 1'b0;
    tick(2);

    cpu_pc = 32'h0000_00A4;
    #1;
    chk("raddr_a4", 64'(imem_raddr), 64'h29);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      pc     = $urandom;
      cpu_pc = pc;
      #1;
      chk("raddr_rand", 64'(imem_raddr), 64'(pc[9:2]));
    end
    send(8'h00);
    send(8'h04);
    tick(20);
    chk("idle_hold", 64'({cpu_hold, load_done, load_err}), 64'd0);
    chk("idle_writes", 64'(nwr), 64'd0);

    prog.delete();
    prog.push_back(32'h0800_0003);
    prog.push_back(32'h0800_0039);
    full_load(2, 8'h3A, 1'b1, 0);

    full_load(2, 8'h3B, 1'b0, 0);
    pulse_req();
    chk("err_cleared", 64'({cpu_hold, load_err}), 64'd2);

    w0 = nwr;
    send_hdr(0);
    chk("hdr_zero_err", 64'(load_err), 64'd1);
    pulse_req();
    send_hdr(257);
    chk("hdr_257_err", 64'(load_err), 64'd1);
    tick(3);
    chk("hdr_no_writes", 64'(nwr - w0), 64'd0);

    for (int k = 0; k < 3; k++) begin
      make_prog($urandom_range(1, 8));
      full_load(prog.size(), csum(), 1'b1, 0);
    end
    make_prog(3);
    full_load(3, csum() ^ 8'h80, 1'b0, 0);

    make_prog(4);
    full_load(4, csum(), 1'b1, 1);
    make_prog(2);
    full_load(2, csum(), 1'b1, 2);

    make_prog(2);
    w0 = nwr;
    pulse_req();
    send_hdr(2);
    send_data(0, 5);
    tick(15);
    chk("tmo_not_yet", 64'(load_err), 64'd0);
    tick(1);
    chk("tmo_err", 64'({cpu_hold, load_err}), 64'd3);
    chk("tmo_writes", 64'(nwr - w0), 64'd1);

    make_prog(2);
    pulse_req();
    send_hdr(2);
    send_data(0, 5);
    tick(15);
    send(byte_of(5));
    chk("tmo_edge_ok", 64'(load_err), 64'd0);
    send_data(6, 8);
    gap();
    send(csum());
    tick(1);
    chk("tmo_edge_done", 64'({cpu_hold, load_done, load_err}), 64'd2);

    make_prog(256);
    full_load(256, csum(), 1'b1, 0);
    chk("last_waddr", 64'(imem_waddr), 64'hFF);

    make_prog(5);
    w0 = nwr;
    pulse_req();
    send_hdr(5);
    send_data(0, 12);
    tick(2);
    reset = 1'b1;
    #1;
    chk("midrst_outputs",
        64'({cpu_hold, imem_we, imem_waddr, imem_wdata,
             load_done, load_err, word_count}), 64'd0);
    chk("midrst_writes", 64'(nwr - w0), 64'd3);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("midrst_run", 64'(cpu_hold), 64'd0);
    chk("final_queue", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
